// File: rtl/bcd_seg_scan.sv
// Four-digit multiplexed seven-segment driver: captures BCD digits, scans one
// digit slot per REFRESH_DIV clocks, with optional leading-zero blanking.
module bcd_seg_scan #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic [3:0] hundreds,
    input  logic [3:0] thousands,
    input  logic       blank_lz,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    logic [CNT_W-1:0] cnt;
    logic [1:0]       slot;
    logic [3:0]       d_ones, d_tens, d_hund, d_thou;

    logic [3:0]       digit;
    logic             blank;
    logic [3:0]       an_nxt;
    logic [6:0]       seg_nxt;

    assign dp = 1'b1;

    // Select the digit for the current slot and decide whether it is a leading zero.
    always_comb begin
        digit = d_ones;
        blank = 1'b0;
        case (slot)
            2'd0: begin
                digit = d_ones;
                blank = 1'b0;
            end
            2'd1: begin
                digit = d_tens;
                blank = blank_lz && (d_thou == 4'd0) && (d_hund == 4'd0) && (d_tens == 4'd0);
            end
            2'd2: begin
                digit = d_hund;
                blank = blank_lz && (d_thou == 4'd0) && (d_hund == 4'd0);
            end
            default: begin
                digit = d_thou;
                blank = blank_lz && (d_thou == 4'd0);
            end
        endcase
    end

    // Active-low {g,f,e,d,c,b,a} decode; non-BCD values render as a dash.
    always_comb begin
        seg_nxt = SEG_DASH;
        an_nxt  = ~(4'b0001 << slot);
        case (digit)
            4'd0:    seg_nxt = 7'b1000000;
            4'd1:    seg_nxt = 7'b1111001;
            4'd2:    seg_nxt = 7'b0100100;
            4'd3:    seg_nxt = 7'b0110000;
            4'd4:    seg_nxt = 7'b0011001;
            4'd5:    seg_nxt = 7'b0010010;
            4'd6:    seg_nxt = 7'b0000010;
            4'd7:    seg_nxt = 7'b1111000;
            4'd8:    seg_nxt = 7'b0000000;
            4'd9:    seg_nxt = 7'b0010000;
            default: seg_nxt = SEG_DASH;
        endcase
        if (blank) begin
            seg_nxt = SEG_OFF;
            an_nxt  = 4'b1111;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            slot   <= 2'd0;
            d_ones <= 4'd0;
            d_tens <= 4'd0;
            d_hund <= 4'd0;
            d_thou <= 4'd0;
            an     <= 4'b1111;
            seg    <= SEG_OFF;
        end else begin
            if (load) begin
                d_ones <= ones;
                d_tens <= tens;
                d_hund <= hundreds;
                d_thou <= thousands;
            end
            if (cnt == CNT_LAST) begin
                cnt  <= '0;
                slot <= slot + 2'd1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            an  <= an_nxt;
            seg <= seg_nxt;
        end
    end

endmodule
